// File: rtl/loa_accumulator.sv
// Approximate multi-cycle accumulator built on a lower-part-OR adder (LOA).
// Sums COUNT unsigned operands into an ACC_W-bit result. The low APPROX_BITS
// bits of each addition are OR-approximated; the upper bits use an exact ripple
// chain of full_adder cells. A sticky flag records any carry out of the MSB.

// Single-bit full adder; one cell of the exact upper ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module loa_accumulator #(
  parameter int unsigned IN_W        = 16,
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned APPROX_BITS = 4,
  parameter int unsigned COUNT       = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  // Beat counter only has to reach COUNT.
  localparam int unsigned CntW = $clog2(COUNT + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAcc  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0]           x;
  logic [ACC_W-1:0]           loa_sum;
  logic                       cin_hi;
  logic [ACC_W:APPROX_BITS]   carry;
  logic                       beat;
  logic                       last_beat;

  assign x = ACC_W'(in_data);

  // LOA lower part: OR approximation, with the top approximate bit pair
  // generating the carry into the exact section.
  if (APPROX_BITS > 0) begin : g_lower
    assign loa_sum[APPROX_BITS-1:0] = acc_q[APPROX_BITS-1:0] | x[APPROX_BITS-1:0];
    assign cin_hi = acc_q[APPROX_BITS-1] & x[APPROX_BITS-1];
  end else begin : g_no_lower
    assign cin_hi = 1'b0;
  end

  assign carry[APPROX_BITS] = cin_hi;

  // Exact upper part: ripple chain of full adders.
  for (genvar i = APPROX_BITS; i < ACC_W; i++) begin : g_ripple
    full_adder u_fa (
      .a    (acc_q[i]),
      .b    (x[i]),
      .cin  (carry[i]),
      .sum  (loa_sum[i]),
      .cout (carry[i+1])
    );
  end

  // in_ready is forced low while reset is asserted, not just after it.
  assign in_ready  = ~rst & (state_q != StDone);
  assign beat      = in_valid & in_ready;
  // cnt_q holds beats already taken, so the COUNT-th beat sees COUNT-1.
  assign last_beat = (cnt_q == CntW'(COUNT - 1));

  // Next-state: accumulate on each beat, park in DONE until the result is taken.
  // acc_q is zero in IDLE, so the first beat needs no special adder path.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StAcc: begin
        if (beat) begin
          acc_d   = loa_sum;
          cnt_d   = cnt_q + CntW'(1);
          ovf_d   = ovf_q | carry[ACC_W];
          state_d = last_beat ? StDone : StAcc;
        end
      end
      StDone: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers; reset discards any partial window immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Result is taken straight from the registers, so it holds under backpressure.
  assign out_valid = (state_q == StDone);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_loa_accumulator.sv
// Self-checking bench for loa_accumulator. Four instances with different
// parameter sets share clock and reset; a plain-arithmetic LOA model supplies
// expected values for randomized windows.
module tb_loa_accumulator;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [3:0]  out_ready;
  wire  [3:0]  in_ready;
  wire  [3:0]  out_valid;
  wire  [3:0]  out_ovf;
  logic [15:0] in_data [4];
  wire  [23:0] sum0;
  wire  [23:0] sum1;
  wire  [15:0] sum2;
  wire  [23:0] sum3;

  // idx: 0 main (k=4,COUNT=9,ACC_W=24), 1 pair (k=4,COUNT=2), 2 wrap (ACC_W=16,k=0,COUNT=2),
  // 3 exact (k=0,COUNT=9)
  int kk_p   [4] = '{4, 4, 0, 0};
  int accw_p [4] = '{24, 24, 16, 24};
  int cnt_p  [4] = '{9, 2, 2, 9};

  int checks = 0;
  int errors = 0;

  loa_accumulator #(.IN_W(16), .ACC_W(24), .APPROX_BITS(4), .COUNT(9)) u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(sum0), .out_ovf(out_ovf[0])
  );

  loa_accumulator #(.IN_W(16), .ACC_W(24), .APPROX_BITS(4), .COUNT(2)) u_pair (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(sum1), .out_ovf(out_ovf[1])
  );

  loa_accumulator #(.IN_W(16), .ACC_W(16), .APPROX_BITS(0), .COUNT(2)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_sum(sum2), .out_ovf(out_ovf[2])
  );

  loa_accumulator #(.IN_W(16), .ACC_W(24), .APPROX_BITS(0), .COUNT(9)) u_exact (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(in_data[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_sum(sum3), .out_ovf(out_ovf[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [23:0] get_sum(input int idx);
    case (idx)
      0:       return sum0;
      1:       return sum1;
      2:       return {8'd0, sum2};
      default: return sum3;
    endcase
  endfunction

  // One LOA addition from the arithmetic definition: OR the low k bits,
  // add the high parts with the carry from bit k-1 pair, wrap at accw.
  function automatic longint unsigned loa_add(input longint unsigned acc,
                                              input longint unsigned x,
                                              input int k, input int accw,
                                              output bit cout);
    longint unsigned mask_k;
    longint unsigned low;
    longint unsigned cin;
    longint unsigned hi;
    longint unsigned full;
    mask_k = (64'd1 << k) - 64'd1;
    low    = (acc | x) & mask_k;
    cin    = (k > 0) ? (((acc >> (k - 1)) & (x >> (k - 1))) & 64'd1) : 64'd0;
    hi     = (acc >> k) + (x >> k) + cin;
    full   = (hi << k) | low;
    cout   = ((full >> accw) & 64'd1) != 0;
    return full & ((64'd1 << accw) - 64'd1);
  endfunction

  function automatic longint unsigned window_model(input int idx, input logic [15:0] ops[$],
                                                   output bit ovf);
    longint unsigned acc;
    bit c;
    acc = 0;
    ovf = 1'b0;
    foreach (ops[i]) begin
      acc = loa_add(acc, {48'd0, ops[i]}, kk_p[idx], accw_p[idx], c);
      ovf = ovf | c;
    end
    return acc;
  endfunction

  // Drives one beat per operand with optional random idle gaps; returns #1 after the last beat.
  task automatic drive_beats(input int idx, input logic [15:0] ops[$], input int max_gap);
    foreach (ops[i]) begin
      repeat ($urandom_range(max_gap, 0)) begin
        in_valid[idx] = 1'b0;
        in_data[idx]  = 16'($urandom);
        @(posedge clk);
        #1;
      end
      in_valid[idx] = 1'b1;
      in_data[idx]  = ops[i];
      @(posedge clk);
      #1;
    end
    in_valid[idx] = 1'b0;
  endtask

  task automatic release_result(input int idx);
    out_ready[idx] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[idx] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ready[%0d]: got %b expected 0", i, in_ready[i]);
      end
      checks++;
      if (out_valid[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_valid[%0d]: got %b expected 0", i, out_valid[i]);
      end
      checks++;
      if (get_sum(i) !== 24'd0) begin
        errors++;
        $display("FAIL reset_out_sum[%0d]: got %0h expected 0", i, get_sum(i));
      end
      checks++;
      if (out_ovf[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out_ovf[%0d]: got %b expected 0", i, out_ovf[i]);
      end
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1) begin
        errors++;
        $display("FAIL release_in_ready[%0d]: got %b expected 1", i, in_ready[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // k=0, COUNT=9: beats 1..9 give exactly 45, valid only after the 9th beat.
  task automatic test_exact_sum();
    logic [15:0] ops[$];
    for (int i = 1; i <= 8; i++) ops.push_back(16'(i));
    drive_beats(3, ops, 0);
    checks++;
    if (out_valid[3] !== 1'b0) begin
      errors++;
      $display("FAIL exact_early_valid: got %b expected 0", out_valid[3]);
    end
    ops = '{16'd9};
    drive_beats(3, ops, 0);
    checks++;
    if (out_valid[3] !== 1'b1) begin
      errors++;
      $display("FAIL exact_valid: got %b expected 1", out_valid[3]);
    end
    checks++;
    if (sum3 !== 24'd45) begin
      errors++;
      $display("FAIL exact_sum: got %0d expected 45", sum3);
    end
    checks++;
    if (out_ovf[3] !== 1'b0) begin
      errors++;
      $display("FAIL exact_ovf: got %b expected 0", out_ovf[3]);
    end
    release_result(3);
    checks++;
    if (out_valid[3] !== 1'b0 || in_ready[3] !== 1'b1) begin
      errors++;
      $display("FAIL exact_handoff: got valid=%b ready=%b expected valid=0 ready=1",
               out_valid[3], in_ready[3]);
    end
  endtask

  // k=4, COUNT=2: 12,8 -> 28 (carry out of approximate part); 3,5 -> 7.
  task automatic test_loa_carry();
    logic [15:0] ops[$];
    ops = '{16'd12, 16'd8};
    drive_beats(1, ops, 1);
    checks++;
    if (out_valid[1] !== 1'b1 || sum1 !== 24'd28) begin
      errors++;
      $display("FAIL loa_12_8: got valid=%b sum=%0d expected valid=1 sum=28", out_valid[1], sum1);
    end
    release_result(1);
    ops = '{16'd3, 16'd5};
    drive_beats(1, ops, 1);
    checks++;
    if (out_valid[1] !== 1'b1 || sum1 !== 24'd7) begin
      errors++;
      $display("FAIL loa_3_5: got valid=%b sum=%0d expected valid=1 sum=7", out_valid[1], sum1);
    end
    release_result(1);
  endtask

  // ACC_W=16: 0xFFFF+1 wraps to 0 with ovf; the next window clears ovf.
  task automatic test_overflow();
    logic [15:0] ops[$];
    ops = '{16'hFFFF, 16'h0001};
    drive_beats(2, ops, 0);
    checks++;
    if (sum2 !== 16'd0) begin
      errors++;
      $display("FAIL wrap_sum: got %0h expected 0", sum2);
    end
    checks++;
    if (out_ovf[2] !== 1'b1) begin
      errors++;
      $display("FAIL wrap_ovf: got %b expected 1", out_ovf[2]);
    end
    release_result(2);
    ops = '{16'd1, 16'd1};
    drive_beats(2, ops, 0);
    checks++;
    if (sum2 !== 16'd2 || out_ovf[2] !== 1'b0) begin
      errors++;
      $display("FAIL wrap_next: got sum=%0d ovf=%b expected sum=2 ovf=0", sum2, out_ovf[2]);
    end
    release_result(2);
  endtask

  // Hold the result 5 cycles while offering beats that must be ignored.
  task automatic test_backpressure();
    logic [15:0] ops[$];
    longint unsigned exp;
    bit exp_ovf;
    for (int i = 0; i < 9; i++) ops.push_back(16'($urandom));
    exp = window_model(0, ops, exp_ovf);
    drive_beats(0, ops, 1);
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 16'($urandom);
      checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || {40'd0, sum0} !== exp) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b sum=%0h expected 1 0 %0h",
                 c, out_valid[0], in_ready[0], sum0, exp);
      end
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    release_result(0);
    checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || sum0 !== 24'd0) begin
      errors++;
      $display("FAIL bp_release: got valid=%b ready=%b sum=%0h expected 0 1 0",
               out_valid[0], in_ready[0], sum0);
    end
    ops = {};
    for (int i = 0; i < 9; i++) ops.push_back(16'($urandom));
    exp = window_model(0, ops, exp_ovf);
    drive_beats(0, ops, 0);
    checks++;
    if (out_valid[0] !== 1'b1 || {40'd0, sum0} !== exp) begin
      errors++;
      $display("FAIL bp_next_window: got valid=%b sum=%0h expected 1 %0h", out_valid[0], sum0, exp);
    end
    release_result(0);
  endtask

  // Async reset part-way through a window, then a clean window of nine 1s.
  task automatic test_reset_mid();
    logic [15:0] ops[$];
    ops = '{16'd5, 16'd5, 16'd5, 16'd5};
    drive_beats(3, ops, 0);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (sum3 !== 24'd0 || out_valid[3] !== 1'b0 || in_ready[3] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: got sum=%0d valid=%b ready=%b expected 0 0 0",
               sum3, out_valid[3], in_ready[3]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready[3] !== 1'b1 || out_valid[3] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: got ready=%b valid=%b expected 1 0",
               in_ready[3], out_valid[3]);
    end
    @(posedge clk);
    #1;
    ops = {};
    for (int i = 0; i < 9; i++) ops.push_back(16'd1);
    drive_beats(3, ops, 0);
    checks++;
    if (out_valid[3] !== 1'b1 || sum3 !== 24'd9) begin
      errors++;
      $display("FAIL mid_reset_sum: got valid=%b sum=%0d expected 1 9", out_valid[3], sum3);
    end
    release_result(3);
  endtask

  task automatic test_random(input int idx, input int windows);
    logic [15:0] ops[$];
    longint unsigned exp;
    bit exp_ovf;
    int hold;
    for (int w = 0; w < windows; w++) begin
      ops = {};
      for (int i = 0; i < cnt_p[idx]; i++) begin
        case ($urandom_range(3, 0))
          0:       ops.push_back(16'($urandom));
          1:       ops.push_back(16'hFF00 | 16'($urandom_range(255, 0)));
          2:       ops.push_back(16'($urandom_range(15, 0)));
          default: ops.push_back(16'($urandom) & 16'h0F0F);
        endcase
      end
      exp = window_model(idx, ops, exp_ovf);
      drive_beats(idx, ops, 2);
      checks++;
      if (out_valid[idx] !== 1'b1 || {40'd0, get_sum(idx)} !== exp || out_ovf[idx] !== exp_ovf) begin
        errors++;
        $display("FAIL rand[%0d] window %0d: got valid=%b sum=%0h ovf=%b expected 1 %0h %b",
                 idx, w, out_valid[idx], get_sum(idx), out_ovf[idx], exp, exp_ovf);
      end
      hold = $urandom_range(3, 0);
      for (int c = 0; c < hold; c++) begin
        @(posedge clk);
        #1;
        checks++;
        if (out_valid[idx] !== 1'b1 || {40'd0, get_sum(idx)} !== exp) begin
          errors++;
          $display("FAIL rand_hold[%0d] window %0d: got valid=%b sum=%0h expected 1 %0h",
                   idx, w, out_valid[idx], get_sum(idx), exp);
        end
      end
      release_result(idx);
      checks++;
      if (out_valid[idx] !== 1'b0) begin
        errors++;
        $display("FAIL rand_release[%0d] window %0d: got valid=%b expected 0", idx, w, out_valid[idx]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    for (int i = 0; i < 4; i++) in_data[i] = '0;
    test_reset();
    test_exact_sum();
    test_loa_carry();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random(0, 1000);
    test_random(1, 300);
    test_random(2, 300);
    test_random(3, 200);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
